// File: rtl/key_port_if.sv
// Bus between the key port and the CPU side: raw switches and event acks in,
// debounced levels, sticky press flags and the interrupt out.
interface key_port_if;
    logic [7:0] nSW;
    logic [7:0] ACK;
    logic [7:0] LEVEL;
    logic [7:0] EVENT;
    logic       IRQ;

    modport master (
        output nSW,
        output ACK,
        input  LEVEL,
        input  EVENT,
        input  IRQ
    );

    modport slave (
        input  nSW,
        input  ACK,
        output LEVEL,
        output EVENT,
        output IRQ
    );
endinterface

// File: rtl/key_port.sv
// Eight-key debouncer: synchronizes active-low switches, accepts a level change only
// after STABLE consecutive disagreeing ticks, and latches sticky press events.
module key_port #(
    parameter int TICK_DIV = 16500,
    parameter int STABLE   = 4
) (
    input  logic        CLK,
    input  logic        nRESET,
    key_port_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE) + 1;
    localparam logic [PW-1:0] LAST_COUNT  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LAST_STABLE = CW'(STABLE - 1);

    logic [7:0]    sync1;
    logic [7:0]    sync2;
    logic [7:0]    s;
    logic [PW-1:0] presc;
    logic          tick;
    logic [CW-1:0] cnt     [8];
    logic [CW-1:0] cnt_nxt [8];
    logic [7:0]    level;
    logic [7:0]    level_nxt;
    logic [7:0]    event_q;
    logic [7:0]    event_nxt;

    // Synchronizer resets to the released (high) state so no press is seen at reset.
    assign s    = ~sync2;
    assign tick = (presc == LAST_COUNT);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync1 <= 8'hFF;
            sync2 <= 8'hFF;
            presc <= '0;
        end else begin
            sync1 <= bus.nSW;
            sync2 <= sync1;
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_comb begin
        level_nxt = level;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick) begin
                if (s[i] == level[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == LAST_STABLE) begin
                    level_nxt[i] = s[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        // A fresh press outranks an ACK arriving on the same edge.
        event_nxt = (level_nxt & ~level) | (event_q & ~bus.ACK);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            level   <= 8'h00;
            event_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level   <= level_nxt;
            event_q <= event_nxt;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.LEVEL = level;
    assign bus.EVENT = event_q;
    assign bus.IRQ   = |event_q;

endmodule

// File: tb/tb_key_port.sv
// Directed bench for key_port with TICK_DIV=4, STABLE=3: a per-tick vector table
// plus hand sequences for reset, one-cycle ACK, ACK/set collision and mid-count reset.
module tb_key_port;

    typedef struct {
        logic [7:0] nsw;
        logic [7:0] ack;
        logic [7:0] level;
        logic [7:0] evt;
        logic       irq;
    } vec_t;

    logic CLK;
    logic nRESET;
    int   checks;
    int   errors;
    vec_t vecs [18];

    key_port_if bus();

    key_port #(
        .TICK_DIV (4),
        .STABLE   (3)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] nsw, input logic [7:0] ack);
        bus.nSW = nsw;
        bus.ACK = ack;
    endtask

    task automatic check_output(input string name, input logic [7:0] exp_level,
                                input logic [7:0] exp_event, input logic exp_irq);
        checks++;
        if (bus.LEVEL !== exp_level) begin
            errors++;
            $display("[TB] FAIL %s LEVEL got=%h want=%h", name, bus.LEVEL, exp_level);
        end
        checks++;
        if (bus.EVENT !== exp_event) begin
            errors++;
            $display("[TB] FAIL %s EVENT got=%h want=%h", name, bus.EVENT, exp_event);
        end
        checks++;
        if (bus.IRQ !== exp_irq) begin
            errors++;
            $display("[TB] FAIL %s IRQ got=%b want=%b", name, bus.IRQ, exp_irq);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Each entry holds nSW for one tick period; expectations are after the next tick edge.
        vecs[0]  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[1]  = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[2]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'hFE, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[6]  = '{8'hF6, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[7]  = '{8'hF6, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[8]  = '{8'hFE, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[9]  = '{8'hF6, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[10] = '{8'hF6, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[11] = '{8'hF6, 8'h00, 8'h09, 8'h09, 1'b1};
        vecs[12] = '{8'hF6, 8'h00, 8'h09, 8'h09, 1'b1};
        vecs[13] = '{8'hF7, 8'h00, 8'h09, 8'h09, 1'b1};
        vecs[14] = '{8'hF7, 8'h00, 8'h09, 8'h09, 1'b1};
        vecs[15] = '{8'hF7, 8'h00, 8'h08, 8'h09, 1'b1};
        vecs[16] = '{8'hF7, 8'h08, 8'h08, 8'h01, 1'b1};
        vecs[17] = '{8'hF7, 8'hFF, 8'h08, 8'h00, 1'b0};

        nRESET = 1'b0;
        apply_stimulus(8'h00, 8'h00);
        step_clk(3);
        check_output("reset_hold", 8'h00, 8'h00, 1'b0);

        // Release on a negedge so tick edges fall on every 4th posedge afterwards.
        @(negedge CLK);
        nRESET = 1'b1;
        step_clk(3);
        check_output("post_reset_pre_tick", 8'h00, 8'h00, 1'b0);
        step_clk(1);
        check_output("post_reset_tick1", 8'h00, 8'h00, 1'b0);
        step_clk(4);
        check_output("post_reset_tick2", 8'h00, 8'h00, 1'b0);
        step_clk(3);
        check_output("post_reset_edge11", 8'h00, 8'h00, 1'b0);
        step_clk(1);
        check_output("post_reset_tick3", 8'hFF, 8'hFF, 1'b1);

        apply_stimulus(8'h00, 8'hFF);
        step_clk(1);
        apply_stimulus(8'h00, 8'h00);
        check_output("ack_all", 8'hFF, 8'h00, 1'b0);
        step_clk(3);

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].nsw, vecs[i].ack);
            step_clk(4);
            check_output($sformatf("vec%0d", i), vecs[i].level, vecs[i].evt, vecs[i].irq);
        end
        apply_stimulus(8'hF7, 8'h00);

        apply_stimulus(8'hF5, 8'h00);
        step_clk(12);
        check_output("press_bit1", 8'h0A, 8'h02, 1'b1);
        apply_stimulus(8'hF5, 8'h02);
        step_clk(1);
        apply_stimulus(8'hF5, 8'h00);
        check_output("ack_pulse_bit1", 8'h0A, 8'h00, 1'b0);
        step_clk(3);

        apply_stimulus(8'hD5, 8'h20);
        step_clk(11);
        check_output("collide_before", 8'h0A, 8'h00, 1'b0);
        step_clk(1);
        check_output("collide_set_edge", 8'h2A, 8'h20, 1'b1);
        step_clk(1);
        check_output("collide_next_edge", 8'h2A, 8'h00, 1'b0);
        apply_stimulus(8'hD5, 8'h00);
        step_clk(3);

        apply_stimulus(8'hD4, 8'h00);
        step_clk(8);
        check_output("partial_count", 8'h2A, 8'h00, 1'b0);
        #1;
        nRESET = 1'b0;
        #1;
        check_output("async_reset_now", 8'h00, 8'h00, 1'b0);
        step_clk(3);
        @(negedge CLK);
        nRESET = 1'b1;
        step_clk(11);
        check_output("rerun_edge11", 8'h00, 8'h00, 1'b0);
        step_clk(1);
        check_output("rerun_tick3", 8'h2B, 8'h2B, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_port.md
KEY_PORT -- requirements
Module: key_port

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16500, meaning clock cycles per sample tick (1 ms at 16.5 MHz); legal range >= 2.
REQ-002 SHALL have parameter STABLE, default 4, meaning the number of consecutive disagreeing ticks needed to accept a level change; legal range >= 1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port nSW, input, 8 bits: raw asynchronous switch lines; 0 = pressed.
REQ-006 SHALL have port ACK, input, 8 bits: per-bit event clear, sampled on each CLK edge.
REQ-007 SHALL have port LEVEL, output, 8 bits: debounced key state; 1 = pressed; feeds the CPU input port.
REQ-008 SHALL have port EVENT, output, 8 bits: sticky press flags.
REQ-009 SHALL have port IRQ, output, 1 bit: OR of all EVENT bits.

Function
REQ-010 SHALL pass each nSW bit through a 2-flop synchronizer; the synchronized sample s[i] is the inverse of the second flop.
REQ-011 SHALL run one prescaler counting 0..TICK_DIV-1 and wrapping to 0.
REQ-012 SHALL assert the internal TICK for exactly one cycle when the prescaler equals TICK_DIV-1.
REQ-013 SHALL keep a per-bit stability counter cnt[i] of width clog2(STABLE)+1 and update it only on TICK cycles.
REQ-014 On a TICK cycle where s[i]==LEVEL[i], SHALL clear cnt[i] to 0.
REQ-015 On a TICK cycle where s[i]!=LEVEL[i] and cnt[i]==STABLE-1, SHALL set LEVEL[i] to s[i] and clear cnt[i].
REQ-016 On a TICK cycle where s[i]!=LEVEL[i] and cnt[i]<STABLE-1, SHALL increment cnt[i].
REQ-017 SHALL ensure any glitch shorter than STABLE consecutive ticks never changes LEVEL.
REQ-018 With STABLE=1, SHALL change LEVEL on the first disagreeing tick.
REQ-019 SHALL set EVENT[i] on the same clock edge at which LEVEL[i] goes 0->1.
REQ-020 SHALL NOT set EVENT on a LEVEL 1->0 transition.
REQ-021 SHALL clear EVENT[i] on an edge where ACK[i]=1 and no set condition exists.
REQ-022 When a set condition and ACK[i]=1 occur on the same edge, SHALL leave EVENT[i]=1 (set wins).
REQ-023 SHALL leave EVENT unchanged by ACK on bits where it is already 0.
REQ-024 SHALL drive IRQ combinationally from registered EVENT bits only; IRQ has no glitch sources from nSW.
REQ-025 SHALL meet a press-detect latency, from a stable nSW change to the LEVEL update, of at least 2+(STABLE-1)*TICK_DIV+1 cycles and at most 2+STABLE*TICK_DIV cycles.
REQ-026 SHALL process all 8 bits independently and simultaneously; there is no priority between bits.

Reset
REQ-027 While nRESET=0, SHALL force: synchronizer flops=1 (released), prescaler=0, all cnt=0, LEVEL=8'h00, EVENT=8'h00, IRQ=0.
REQ-028 SHALL apply reset asynchronously, including mid-count or mid-debounce; no partial state survives.
REQ-029 After nRESET rises, the prescaler SHALL start from 0 on the first CLK edge.

Verification (TICK_DIV=4, STABLE=3)
REQ-030 Reset: hold nRESET=0 with nSW=8'h00 -> LEVEL=00, EVENT=00, IRQ=0 throughout; after release, LEVEL rises to FF no earlier than the 3rd TICK.
REQ-031 Clean press: nSW[0] 1->0 and held -> LEVEL[0]=1 within 2+12 cycles, EVENT[0]=1 on the same edge, IRQ=1; pulse ACK=01 for one cycle -> EVENT=00, IRQ=0, LEVEL[0] stays 1.
REQ-032 Bounce: nSW[3] low for 2 ticks, high for 1 tick, then low steadily -> no LEVEL change until 3 consecutive low ticks; exactly one EVENT[3] set.
REQ-033 Release: a pressed bit returns high for 3 ticks -> LEVEL bit goes 0 and EVENT stays unchanged.
REQ-034 Collision: hold ACK[5]=1 continuously while bit 5 becomes pressed -> EVENT[5]=1 for exactly the set edge, cleared on the next edge.
REQ-035 Mid-operation reset: assert nRESET during a partially counted press -> all outputs 0 immediately, without waiting for a CLK edge; after release, a full STABLE-tick count is required.
